bsg_cam_1r1w_plru: RTL and testbench
====================================

Name: bsg_cam_1r1w_plru

Overview:
- Managed successor to the unmanaged 1r1w CAM: same tag/data storage, asynchronous tag read and synchronous write.
- Replacement is internal, using a tree pseudo-LRU: in-place update on hit, fill of the lowest empty entry, otherwise eviction of the PLRU victim.
- Reports the evicted tag/data so an upstream TLB or victim buffer can write back.
- Adds invalidate-by-tag and a single-cycle flush.

Parameters:
- els_p, 8, number of entries; power of 2, >= 2.
- tag_width_p, 16, tag width.
- data_width_p, 32, data width.
- lg_els_lp, `BSG_SAFE_CLOG2(els_p), derived; not user-set.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- w_v_i  in  1  write/clear request valid.
- w_set_not_clear_i  in  1  1 = insert/update tag; 0 = invalidate tag.
- w_tag_i  in  tag_width_p  tag to insert or invalidate.
- w_data_i  in  data_width_p  data for insert/update.
- w_evict_v_o  out  1  this insert displaces a valid entry (combinational).
- w_evict_tag_o  out  tag_width_p  tag of displaced entry.
- w_evict_data_o  out  data_width_p  data of displaced entry.
- flush_i  in  1  invalidate all entries and reset PLRU.
- r_v_i  in  1  read request valid.
- r_tag_i  in  tag_width_p  lookup tag.
- r_data_o  out  data_width_p  data of matching entry; 0 on miss.
- r_v_o  out  1  hit = r_v_i & match on a valid entry (combinational).
- full_o  out  1  all entries valid.
- empty_o  out  1  no entry valid.

Behaviour:
- State:
  - valid_r[els_p], tag_r, data_r.
  - plru_r[els_p-1]: heap-ordered tree, node 0 = root, children of node n are 2n+1 and 2n+2.
  - Node bit 0 = victim lies in the lower-index subtree.
- Reset (async, reset_n_i low): valid_r = 0, plru_r = 0 → victim = entry 0. Tag/data arrays are not reset.
- Outputs during reset: r_v_o = 0, r_data_o = 0, w_evict_v_o = 0, full_o = 0, empty_o = 1.
- Read:
  - Purely combinational, zero latency.
  - Match = valid & tag equal; at most one match (guaranteed by the write rule below).
  - A read hit "touches" its entry at the next edge: path bits set to point away from it.
- Insert (w_v_i & w_set_not_clear_i):
  - Target is, in priority order:
    - the matching valid entry (update data, no eviction);
    - else the lowest-index invalid entry;
    - else the PLRU victim.
  - w_evict_v_o = 1 only in the victim case; w_evict_tag_o / w_evict_data_o = the victim's current contents. They are 0 when w_evict_v_o = 0.
  - At the edge: valid = 1, tag/data written, target touched.
- Clear (w_v_i & ~w_set_not_clear_i):
  - Matching entry's valid is cleared; no PLRU change.
  - Clear of an absent tag has no effect.
  - w_evict_v_o = 0.
- Simultaneous read hit and insert in the same cycle:
  - Both touches apply.
  - On tree nodes common to both paths, the write touch wins.
  - Read data reflects pre-write contents (read-before-write).
- Read hit and clear of the same tag in the same cycle: read returns old data, r_v_o = 1; the entry is invalid next cycle.
- flush_i:
  - Highest priority; any w_v_i and any read touch in that cycle are discarded.
  - Next cycle: valid = 0, plru_r = 0.
  - r_v_o is still computed from the current state during the flush cycle.
- w_v_i with flush_i: no eviction reported (w_evict_v_o = 0).
- Reset asserted mid-operation: state clears immediately, asynchronously; no partial write survives.
- Flags: full_o = &valid_r, empty_o = ~|valid_r; both from registered state.
- Assertions (simulation only): els_p is a power of 2 and >= 2; never more than one valid match per tag.

Test Plan (els_p=4):
- Reset, then insert tags 0xA,0xB,0xC,0xD with data 1..4 → entries 0..3 fill in order; no evict; full_o = 1 after the 4th write; read 0xC → r_v_o = 1, r_data_o = 3.
- After fill with no reads, insert 0xE/5 → w_evict_v_o = 1, w_evict_tag_o = 0xA, w_evict_data_o = 1; read 0xA next cycle → miss.
- Fill, read 0xA (touch), then insert 0xE → victim = 0xC (entry 2), per tree bits root=0→left touched→points right; evict tag 0xC.
- Insert an existing tag 0xB with data 9 → w_evict_v_o = 0; occupancy unchanged; read 0xB → 9.
- Clear 0xB, then insert 0xF → fills entry 1 with no eviction; clear an absent tag 0x7 → no state change.
- Flush while w_v_i = 1 with a new tag → next cycle empty_o = 1, all reads miss; the following insert lands in entry 0.
- Assert reset_n_i low asynchronously between edges after fill → empty_o = 1 immediately; reads miss.

Source files
------------

// File: rtl/bsg_cam_1r1w_plru.sv
// bsg_cam_1r1w_plru
//   Managed 1-read / 1-write content-addressable memory with tree pseudo-LRU
//   replacement. Tag lookup is combinational. Writes happen on the rising edge.
//   An insert updates a matching entry in place. If no entry matches, it fills
//   the lowest empty entry. If the CAM is full, it evicts the PLRU victim and
//   reports the displaced tag/data so upstream logic can write it back.
//
// Ports
//   clk_i              clock, all state updates on rising edge
//   reset_n_i          asynchronous active-low reset
//   w_v_i              write/clear request valid
//   w_set_not_clear_i  1 = insert/update, 0 = invalidate by tag
//   w_tag_i, w_data_i  tag and data for the write port
//   w_evict_v_o        insert displaces a valid entry (combinational)
//   w_evict_tag_o      tag of the displaced entry (0 when no eviction)
//   w_evict_data_o     data of the displaced entry (0 when no eviction)
//   flush_i            invalidate everything and reset PLRU (highest priority)
//   r_v_i, r_tag_i     lookup request
//   r_data_o           data of matching entry, 0 on miss
//   r_v_o              read hit
//   full_o, empty_o    occupancy flags from registered state
module bsg_cam_1r1w_plru #(
  parameter int els_p        = 8,
  parameter int tag_width_p  = 16,
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    w_v_i,
  input  logic                    w_set_not_clear_i,
  input  logic [tag_width_p-1:0]  w_tag_i,
  input  logic [data_width_p-1:0] w_data_i,
  output logic                    w_evict_v_o,
  output logic [tag_width_p-1:0]  w_evict_tag_o,
  output logic [data_width_p-1:0] w_evict_data_o,
  input  logic                    flush_i,
  input  logic                    r_v_i,
  input  logic [tag_width_p-1:0]  r_tag_i,
  output logic [data_width_p-1:0] r_data_o,
  output logic                    r_v_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [els_p-1:0]        r_valid;
  logic [els_p-2:0]        r_plru;
  logic [tag_width_p-1:0]  r_tag  [els_p];
  logic [data_width_p-1:0] r_data [els_p];

  logic [els_p-1:0]        w_r_match;
  logic [els_p-1:0]        w_w_match;
  logic [lg_els_lp-1:0]    w_r_idx;
  logic [lg_els_lp-1:0]    w_w_idx;
  logic [lg_els_lp-1:0]    w_empty_idx;
  logic [lg_els_lp-1:0]    w_victim_idx;
  logic [lg_els_lp-1:0]    w_tgt_idx;
  logic                    w_w_hit;
  logic                    w_has_empty;
  logic                    w_insert;
  logic                    w_clear;
  logic [data_width_p-1:0] w_rd_data;
  logic [els_p-1:0]        w_valid_next;
  logic [els_p-2:0]        w_plru_next;

  // Point every node on the path to entry e away from e. Node bit 0 means
  // the victim lies in the lower-index subtree, so stepping left sets the bit.
  function automatic logic [els_p-2:0] touch(input logic [els_p-2:0] t,
                                             input logic [lg_els_lp-1:0] e);
    logic [els_p-2:0] res;
    int node;
    res = t;
    for (int l = 0; l < lg_els_lp; l++) begin
      node      = (1 << l) - 1 + (int'(e) >> (lg_els_lp - l));
      res[node] = ~e[lg_els_lp-1-l];
    end
    return res;
  endfunction

  // Tag match vectors. Valid gating keeps stale tags out of the compare.
  always_comb begin
    for (int i = 0; i < els_p; i++) begin
      w_r_match[i] = r_valid[i] & (r_tag[i] == r_tag_i);
      w_w_match[i] = r_valid[i] & (r_tag[i] == w_tag_i);
    end
  end

  // Encoders. Matches are one-hot, so the highest index that matches is the
  // only index that matches. The empty search runs downward so that the
  // lowest invalid entry is the one kept.
  always_comb begin
    w_r_idx     = '0;
    w_w_idx     = '0;
    w_empty_idx = '0;
    w_rd_data   = '0;
    for (int i = 0; i < els_p; i++) begin
      if (w_r_match[i]) begin
        w_r_idx   = lg_els_lp'(i);
        w_rd_data = r_data[i];
      end
      if (w_w_match[i]) w_w_idx = lg_els_lp'(i);
    end
    for (int i = els_p - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_empty_idx = lg_els_lp'(i);
    end
  end

  // Walk the tree from the root to find the PLRU victim leaf.
  always_comb begin
    int n;
    n = 0;
    for (int l = 0; l < lg_els_lp; l++) begin
      n = r_plru[n] ? (2 * n + 2) : (2 * n + 1);
    end
    w_victim_idx = lg_els_lp'(n - (els_p - 1));
  end

  assign w_w_hit     = |w_w_match;
  assign w_has_empty = ~&r_valid;
  assign w_insert    = w_v_i & w_set_not_clear_i;
  assign w_clear     = w_v_i & ~w_set_not_clear_i;
  assign w_tgt_idx   = w_w_hit     ? w_w_idx     :
                       w_has_empty ? w_empty_idx : w_victim_idx;

  assign r_v_o    = r_v_i & (|w_r_match);
  assign r_data_o = r_v_o ? w_rd_data : '0;

  assign w_evict_v_o    = w_insert & ~flush_i & ~w_w_hit & ~w_has_empty;
  assign w_evict_tag_o  = w_evict_v_o ? r_tag[w_victim_idx]  : '0;
  assign w_evict_data_o = w_evict_v_o ? r_data[w_victim_idx] : '0;

  assign full_o  = &r_valid;
  assign empty_o = ~|r_valid;

  // Next state. The write touch is applied after the read touch so that the
  // write wins on tree nodes the two paths share.
  always_comb begin
    w_valid_next = r_valid;
    w_plru_next  = r_plru;
    if (r_v_o)    w_plru_next = touch(w_plru_next, w_r_idx);
    if (w_insert) begin
      w_plru_next             = touch(w_plru_next, w_tgt_idx);
      w_valid_next[w_tgt_idx] = 1'b1;
    end else if (w_clear && w_w_hit) begin
      w_valid_next[w_w_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_valid <= '0;
      r_plru  <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
      r_plru  <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_plru  <= w_plru_next;
    end
  end

  // Tag/data storage is not reset. The valid bits alone decide visibility.
  always_ff @(posedge clk_i) begin
    if (w_insert && !flush_i) begin
      r_tag[w_tgt_idx]  <= w_tag_i;
      r_data[w_tgt_idx] <= w_data_i;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (els_p >= 2 && (els_p & (els_p - 1)) == 0)
        else $error("els_p must be a power of 2 and >= 2");
      assert ($onehot0(w_r_match)) else $error("multiple read matches");
      assert ($onehot0(w_w_match)) else $error("multiple write matches");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_cam_1r1w_plru.sv
module tb_bsg_cam_1r1w_plru;

  logic        clk;
  logic        reset_n;
  logic        w_v;
  logic        w_set;
  logic [15:0] w_tag;
  logic [31:0] w_data;
  logic        ev_v;
  logic [15:0] ev_tag;
  logic [31:0] ev_data;
  logic        flush;
  logic        r_v;
  logic [15:0] r_tag;
  logic [31:0] r_data;
  logic        r_vo;
  logic        full;
  logic        empty;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb[$];
  logic [31:0] e;

  bsg_cam_1r1w_plru #(.els_p(4), .tag_width_p(16), .data_width_p(32)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .w_v_i(w_v), .w_set_not_clear_i(w_set), .w_tag_i(w_tag), .w_data_i(w_data),
    .w_evict_v_o(ev_v), .w_evict_tag_o(ev_tag), .w_evict_data_o(ev_data),
    .flush_i(flush), .r_v_i(r_v), .r_tag_i(r_tag), .r_data_o(r_data),
    .r_v_o(r_vo), .full_o(full), .empty_o(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    w_v = 0; w_set = 0; flush = 0; r_v = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1
  // unit later, well away from either clock edge.
  task automatic step();
    @(posedge clk); #1; idle();
  endtask

  task automatic wr(input logic set, input logic [15:0] tag, input logic [31:0] data);
    w_v = 1; w_set = set; w_tag = tag; w_data = data;
  endtask

  task automatic rd(input logic [15:0] tag);
    r_v = 1; r_tag = tag;
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset_n = 0; #1; reset_n = 1;
    @(posedge clk); #1; idle();
  endtask

  task automatic fill();
    for (int i = 0; i < 4; i++) begin
      wr(1, 16'hA + 16'(i), 32'(i + 1));
      step();
    end
  endtask

  task automatic test_reset();
    wr(1, 16'h1, 32'h1); rd(16'h1);
    sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(32'd0);
    sb.push_back(32'd1); sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL reset_r_v: got %0h want %0h", r_vo, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_data !== e) begin n_bad++; $display("FAIL reset_r_data: got %0h want %0h", r_data, e); end
    e = sb.pop_front(); n_cmp++;
    if (ev_v !== e[0]) begin n_bad++; $display("FAIL reset_evict_v: got %0h want %0h", ev_v, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (empty !== e[0]) begin n_bad++; $display("FAIL reset_empty: got %0h want %0h", empty, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (full !== e[0]) begin n_bad++; $display("FAIL reset_full: got %0h want %0h", full, e[0]); end
    idle();
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      wr(1, 16'hA + 16'(i), 32'(i + 1));
      sb.push_back(32'd0);
      #1;
      e = sb.pop_front(); n_cmp++;
      if (ev_v !== e[0]) begin n_bad++; $display("FAIL fill_evict_v[%0d]: got %0h want %0h", i, ev_v, e[0]); end
      step();
    end
    rd(16'hC);
    sb.push_back(32'd1); sb.push_back(32'd1); sb.push_back(32'd3);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (full !== e[0]) begin n_bad++; $display("FAIL fill_full: got %0h want %0h", full, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL fill_read_hit: got %0h want %0h", r_vo, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_data !== e) begin n_bad++; $display("FAIL fill_read_data: got %0h want %0h", r_data, e); end
    step();
  endtask

  task automatic test_evict_lru();
    pulse_reset(); fill();
    wr(1, 16'hE, 32'd5);
    sb.push_back(32'd1); sb.push_back(32'hA); sb.push_back(32'd1);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (ev_v !== e[0]) begin n_bad++; $display("FAIL lru_evict_v: got %0h want %0h", ev_v, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (ev_tag !== e[15:0]) begin n_bad++; $display("FAIL lru_evict_tag: got %0h want %0h", ev_tag, e[15:0]); end
    e = sb.pop_front(); n_cmp++;
    if (ev_data !== e) begin n_bad++; $display("FAIL lru_evict_data: got %0h want %0h", ev_data, e); end
    step();
    rd(16'hA);
    sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL lru_old_tag_miss: got %0h want %0h", r_vo, e[0]); end
    rd(16'hE);
    sb.push_back(32'd5);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (r_data !== e) begin n_bad++; $display("FAIL lru_new_data: got %0h want %0h", r_data, e); end
    step();
  endtask

  task automatic test_touch();
    pulse_reset(); fill();
    rd(16'hA);
    step();
    wr(1, 16'hE, 32'd5);
    sb.push_back(32'd1); sb.push_back(32'hC); sb.push_back(32'd3);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (ev_v !== e[0]) begin n_bad++; $display("FAIL touch_evict_v: got %0h want %0h", ev_v, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (ev_tag !== e[15:0]) begin n_bad++; $display("FAIL touch_evict_tag: got %0h want %0h", ev_tag, e[15:0]); end
    e = sb.pop_front(); n_cmp++;
    if (ev_data !== e) begin n_bad++; $display("FAIL touch_evict_data: got %0h want %0h", ev_data, e); end
    step();
  endtask

  task automatic test_update_clear();
    pulse_reset(); fill();
    wr(1, 16'hB, 32'd9);
    sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (ev_v !== e[0]) begin n_bad++; $display("FAIL upd_evict_v: got %0h want %0h", ev_v, e[0]); end
    step();
    rd(16'hB);
    sb.push_back(32'd1); sb.push_back(32'd9);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (full !== e[0]) begin n_bad++; $display("FAIL upd_full: got %0h want %0h", full, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_data !== e) begin n_bad++; $display("FAIL upd_read_data: got %0h want %0h", r_data, e); end
    idle();
    wr(0, 16'hB, 32'd0);
    step();
    rd(16'hB);
    sb.push_back(32'd0); sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (full !== e[0]) begin n_bad++; $display("FAIL clr_full: got %0h want %0h", full, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL clr_read_miss: got %0h want %0h", r_vo, e[0]); end
    idle();
    wr(1, 16'hF, 32'd7);
    sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (ev_v !== e[0]) begin n_bad++; $display("FAIL refill_evict_v: got %0h want %0h", ev_v, e[0]); end
    step();
    wr(0, 16'h7, 32'd0);
    step();
    rd(16'hF);
    sb.push_back(32'd1); sb.push_back(32'd7);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (full !== e[0]) begin n_bad++; $display("FAIL clr_absent_full: got %0h want %0h", full, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_data !== e) begin n_bad++; $display("FAIL refill_read_data: got %0h want %0h", r_data, e); end
    step();
    // 0xF landed in entry 1, so the tree now points at entry 2 (0xC).
    wr(1, 16'h10, 32'd8);
    sb.push_back(32'hC); sb.push_back(32'd3);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (ev_tag !== e[15:0]) begin n_bad++; $display("FAIL refill_victim_tag: got %0h want %0h", ev_tag, e[15:0]); end
    e = sb.pop_front(); n_cmp++;
    if (ev_data !== e) begin n_bad++; $display("FAIL refill_victim_data: got %0h want %0h", ev_data, e); end
    step();
  endtask

  task automatic test_back_to_back();
    pulse_reset(); fill();
    // Read entry 2 while inserting a new tag that evicts entry 0.
    rd(16'hC); wr(1, 16'hE, 32'd5);
    sb.push_back(32'd1); sb.push_back(32'd3); sb.push_back(32'hA);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL b2b_read_hit: got %0h want %0h", r_vo, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_data !== e) begin n_bad++; $display("FAIL b2b_read_data: got %0h want %0h", r_data, e); end
    e = sb.pop_front(); n_cmp++;
    if (ev_tag !== e[15:0]) begin n_bad++; $display("FAIL b2b_evict_tag: got %0h want %0h", ev_tag, e[15:0]); end
    step();
    // Root follows the write, the right subtree keeps the read touch -> entry 3.
    wr(1, 16'h1F, 32'd6);
    sb.push_back(32'hD); sb.push_back(32'd4);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (ev_tag !== e[15:0]) begin n_bad++; $display("FAIL b2b_merge_tag: got %0h want %0h", ev_tag, e[15:0]); end
    e = sb.pop_front(); n_cmp++;
    if (ev_data !== e) begin n_bad++; $display("FAIL b2b_merge_data: got %0h want %0h", ev_data, e); end
    step();
    // Read and clear of the same tag in one cycle.
    rd(16'hB); wr(0, 16'hB, 32'd0);
    sb.push_back(32'd1); sb.push_back(32'd2);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL rdclr_hit: got %0h want %0h", r_vo, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_data !== e) begin n_bad++; $display("FAIL rdclr_data: got %0h want %0h", r_data, e); end
    step();
    rd(16'hB);
    sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL rdclr_after: got %0h want %0h", r_vo, e[0]); end
    step();
  endtask

  task automatic test_flush();
    pulse_reset(); fill();
    flush = 1; wr(1, 16'h55, 32'h77); rd(16'hA);
    sb.push_back(32'd1); sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL flush_cycle_hit: got %0h want %0h", r_vo, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (ev_v !== e[0]) begin n_bad++; $display("FAIL flush_evict_v: got %0h want %0h", ev_v, e[0]); end
    step();
    rd(16'h55);
    sb.push_back(32'd1); sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (empty !== e[0]) begin n_bad++; $display("FAIL flush_empty: got %0h want %0h", empty, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL flush_new_tag_miss: got %0h want %0h", r_vo, e[0]); end
    rd(16'hA);
    sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL flush_old_tag_miss: got %0h want %0h", r_vo, e[0]); end
    idle();
    // Refill after flush: first insert lands in entry 0, the initial victim.
    for (int i = 0; i < 4; i++) begin
      wr(1, 16'h21 + 16'(i), 32'h31 + 32'(i));
      step();
    end
    wr(1, 16'h40, 32'h41);
    sb.push_back(32'h21); sb.push_back(32'h31);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (ev_tag !== e[15:0]) begin n_bad++; $display("FAIL postflush_victim_tag: got %0h want %0h", ev_tag, e[15:0]); end
    e = sb.pop_front(); n_cmp++;
    if (ev_data !== e) begin n_bad++; $display("FAIL postflush_victim_data: got %0h want %0h", ev_data, e); end
    step();
  endtask

  task automatic test_async_reset();
    pulse_reset(); fill();
    #2;
    reset_n = 0;
    rd(16'hA);
    sb.push_back(32'd1); sb.push_back(32'd0); sb.push_back(32'd0);
    #1;
    e = sb.pop_front(); n_cmp++;
    if (empty !== e[0]) begin n_bad++; $display("FAIL areset_empty: got %0h want %0h", empty, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (full !== e[0]) begin n_bad++; $display("FAIL areset_full: got %0h want %0h", full, e[0]); end
    e = sb.pop_front(); n_cmp++;
    if (r_vo !== e[0]) begin n_bad++; $display("FAIL areset_read_miss: got %0h want %0h", r_vo, e[0]); end
    #1;
    reset_n = 1;
    idle();
    step();
  endtask

  initial begin
    reset_n = 0; idle(); w_tag = '0; w_data = '0; r_tag = '0;
    #2;
    test_reset();
    test_fill();
    test_evict_lru();
    test_touch();
    test_update_clear();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
